// File: rtl/store_buffer_if.sv
// Store-buffer bundle: store push, load probe/forward, and the data-memory drain port.
interface store_buffer_if;
  logic        St_Valid;
  logic [31:0] St_Address;
  logic [31:0] St_Data;
  logic [1:0]  St_Control;
  logic        St_Ready;
  logic        Ld_Valid;
  logic [31:0] Ld_Address;
  logic [1:0]  Ld_Control;
  logic        Ld_Stall;
  logic        Fwd_Hit;
  logic [31:0] Fwd_Data;
  logic        Mem_Write;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic [1:0]  Mem_Store_Control;
  logic        Empty;

  modport master (
    output St_Valid, St_Address, St_Data, St_Control, Ld_Valid, Ld_Address, Ld_Control,
    input  St_Ready, Ld_Stall, Fwd_Hit, Fwd_Data, Mem_Write, Mem_Address, Mem_Write_Data,
           Mem_Store_Control, Empty
  );

  modport slave (
    input  St_Valid, St_Address, St_Data, St_Control, Ld_Valid, Ld_Address, Ld_Control,
    output St_Ready, Ld_Stall, Fwd_Hit, Fwd_Data, Mem_Write, Mem_Address, Mem_Write_Data,
           Mem_Store_Control, Empty
  );
endinterface

// File: rtl/store_buffer.sv
// DEPTH-entry store FIFO draining one store per cycle (visible at head one cycle after push; St_Ready=0 when full).
// Loads hitting a pending store are forwarded (STORE_FWD_EN defined, sw only) or stalled until the match drains.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic          Clk,
  input logic          Rst,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [1:0]       r_ctrl [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_match;
  logic [AW-1:0] w_match_idx;
  logic [AW-1:0] w_idx;
  logic          w_stall;
  logic          w_hit;
  logic [31:0]   w_fwd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = bus.St_Valid && !w_full;
  assign w_pop   = !Rst && !w_empty && (!bus.Ld_Valid || w_stall);

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = r_head;
    w_idx       = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if (r_valid[w_idx] && (r_addr[w_idx][15:2] == bus.Ld_Address[15:2])) begin
        w_match     = 1'b1;
        w_match_idx = w_idx;
      end
    end
  end

`ifdef STORE_FWD_EN
  function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] c);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b11:   b = w[7:0];
      2'b10:   b = w[15:8];
      2'b01:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[0] ? w[15:0] : w[31:16];
    r = w;
    if (c == 2'b10)      r = {{24{b[7]}}, b};
    else if (c == 2'b11) r = a[1] ? 32'h0 : {{16{h[15]}}, h};
    return r;
  endfunction

  logic w_match_sw;
  assign w_match_sw = (r_ctrl[w_match_idx][1] == 1'b0);
  assign w_stall    = bus.Ld_Valid && w_match && !w_match_sw;
  assign w_hit      = bus.Ld_Valid && w_match && w_match_sw;
  assign w_fwd      = w_hit ? f_extract(r_data[w_match_idx], bus.Ld_Address[1:0], bus.Ld_Control)
                            : 32'h0;
`else
  assign w_stall = bus.Ld_Valid && w_match;
  assign w_hit   = 1'b0;
  assign w_fwd   = 32'h0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.St_Address;
        r_data[r_tail]  <= bus.St_Data;
        r_ctrl[r_tail]  <= bus.St_Control;
        r_tail          <= r_tail + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.St_Ready          = !w_full;
  assign bus.Empty             = w_empty;
  assign bus.Ld_Stall          = w_stall;
  assign bus.Fwd_Hit           = w_hit;
  assign bus.Fwd_Data          = w_fwd;
  assign bus.Mem_Write         = w_pop;
  assign bus.Mem_Address       = r_addr[r_head];
  assign bus.Mem_Write_Data    = r_data[r_head];
  assign bus.Mem_Store_Control = r_ctrl[r_head];
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: expected drains are queued on push and compared as Mem_Write fires.
module tb_store_buffer;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  store_buffer_if bus();
  store_buffer #(.DEPTH(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  c;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  drained = 0;

  always @(negedge Clk) begin
    if (bus.Mem_Write === 1'b1) begin
      drained++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL drain_unexpected got addr=%h (no store pending)", bus.Mem_Address);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.Mem_Address !== mon_exp.a || bus.Mem_Write_Data !== mon_exp.d ||
            bus.Mem_Store_Control !== mon_exp.c)
          $display("FAIL drain_order got %h/%h/%b exp %h/%h/%b", bus.Mem_Address,
                   bus.Mem_Write_Data, bus.Mem_Store_Control, mon_exp.a, mon_exp.d, mon_exp.c);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic hold_load(input logic [31:0] a, input logic [1:0] c);
    bus.Ld_Valid   = 1'b1;
    bus.Ld_Address = a;
    bus.Ld_Control = c;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c,
                      input bit accept);
    bus.St_Valid   = 1'b1;
    bus.St_Address = a;
    bus.St_Data    = d;
    bus.St_Control = c;
    if (accept) exp_q.push_back({a, d, c});
    tick();
    bus.St_Valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (bus.Empty !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (bus.Empty !== 1'b1) $display("FAIL %s_drain_timeout got Empty=%b exp 1", name, bus.Empty); else pass_cnt++;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    @(negedge Clk);
    total_cnt++; if (bus.Empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", bus.Empty); else pass_cnt++;
    total_cnt++; if (bus.St_Ready !== 1'b1) $display("FAIL reset_st_ready got %b exp 1", bus.St_Ready); else pass_cnt++;
    total_cnt++; if (bus.Mem_Write !== 1'b0) $display("FAIL reset_mem_write got %b exp 0", bus.Mem_Write); else pass_cnt++;
    total_cnt++; if (bus.Mem_Address !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", bus.Mem_Address); else pass_cnt++;
    total_cnt++; if (bus.Mem_Write_Data !== 32'h0) $display("FAIL reset_mem_data got %h exp 0", bus.Mem_Write_Data); else pass_cnt++;
    total_cnt++; if (bus.Mem_Store_Control !== 2'b00) $display("FAIL reset_mem_ctrl got %b exp 0", bus.Mem_Store_Control); else pass_cnt++;
    total_cnt++; if (bus.Fwd_Hit !== 1'b0 || bus.Ld_Stall !== 1'b0 || bus.Fwd_Data !== 32'h0)
      $display("FAIL reset_load_outs got hit=%b stall=%b data=%h exp 0/0/0", bus.Fwd_Hit, bus.Ld_Stall, bus.Fwd_Data); else pass_cnt++;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_drain_one();
    push(32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1'b1);
    @(negedge Clk);
    total_cnt++; if (bus.Mem_Write !== 1'b1) $display("FAIL drain_one_write got %b exp 1", bus.Mem_Write); else pass_cnt++;
    total_cnt++; if (bus.Mem_Address !== 32'h10) $display("FAIL drain_one_addr got %h exp 10", bus.Mem_Address); else pass_cnt++;
    tick();
    total_cnt++; if (bus.Empty !== 1'b1) $display("FAIL drain_one_empty got %b exp 1", bus.Empty); else pass_cnt++;
  endtask

  task automatic test_full();
    int d0;
    hold_load(32'h0000_1000, 2'b00);
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b00, 1'b1);
    @(negedge Clk);
    total_cnt++; if (bus.St_Ready !== 1'b0) $display("FAIL full_st_ready got %b exp 0", bus.St_Ready); else pass_cnt++;
    total_cnt++; if (bus.Mem_Write !== 1'b0) $display("FAIL full_held_write got %b exp 0", bus.Mem_Write); else pass_cnt++;
    tick();
    push(32'h200, 32'hBAD0_BAD0, 2'b00, 1'b0);
    bus.Ld_Valid = 1'b0;
    d0 = drained;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total_cnt++; if (bus.Mem_Write !== 1'b1) $display("FAIL full_drain_cycle%0d got %b exp 1", i, bus.Mem_Write); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.Empty !== 1'b1 || drained - d0 != 4)
      $display("FAIL full_drain_count got empty=%b n=%0d exp 1/4", bus.Empty, drained - d0); else pass_cnt++;
  endtask

  task automatic test_forward();
    hold_load(32'h0000_1000, 2'b00);
    push(32'h0000_0020, 32'h80FF_1234, 2'b00, 1'b1);
    hold_load(32'h0000_0023, 2'b10);
    #1;
`ifdef STORE_FWD_EN
    total_cnt++; if (bus.Fwd_Hit !== 1'b1 || bus.Fwd_Data !== 32'h0000_0034 || bus.Ld_Stall !== 1'b0)
      $display("FAIL fwd_lb got hit=%b data=%h stall=%b exp 1/00000034/0", bus.Fwd_Hit, bus.Fwd_Data, bus.Ld_Stall); else pass_cnt++;
    total_cnt++; if (bus.Mem_Write !== 1'b0) $display("FAIL fwd_no_drain got %b exp 0", bus.Mem_Write); else pass_cnt++;
    hold_load(32'h0000_0020, 2'b11);
    #1;
    total_cnt++; if (bus.Fwd_Data !== 32'hFFFF_80FF) $display("FAIL fwd_lh got %h exp ffff80ff", bus.Fwd_Data); else pass_cnt++;
    hold_load(32'h0000_0022, 2'b00);
    #1;
    total_cnt++; if (bus.Fwd_Data !== 32'h80FF_1234) $display("FAIL fwd_lw got %h exp 80ff1234", bus.Fwd_Data); else pass_cnt++;
    hold_load(32'h0000_0022, 2'b11);
    #1;
    total_cnt++; if (bus.Fwd_Hit !== 1'b1 || bus.Fwd_Data !== 32'h0) $display("FAIL fwd_lh_misaligned got hit=%b data=%h exp 1/0", bus.Fwd_Hit, bus.Fwd_Data); else pass_cnt++;
`else
    total_cnt++; if (bus.Ld_Stall !== 1'b1 || bus.Fwd_Hit !== 1'b0 || bus.Fwd_Data !== 32'h0)
      $display("FAIL nofwd_lb got stall=%b hit=%b data=%h exp 1/0/0", bus.Ld_Stall, bus.Fwd_Hit, bus.Fwd_Data); else pass_cnt++;
    total_cnt++; if (bus.Mem_Write !== 1'b1) $display("FAIL nofwd_drain got %b exp 1", bus.Mem_Write); else pass_cnt++;
    hold_load(32'h0000_0020, 2'b11);
    #1;
    total_cnt++; if (bus.Ld_Stall !== 1'b1 || bus.Fwd_Data !== 32'h0) $display("FAIL nofwd_lh got stall=%b data=%h exp 1/0", bus.Ld_Stall, bus.Fwd_Data); else pass_cnt++;
`endif
    bus.Ld_Valid = 1'b0;
    #1;
    total_cnt++; if (bus.Fwd_Hit !== 1'b0 || bus.Ld_Stall !== 1'b0 || bus.Fwd_Data !== 32'h0)
      $display("FAIL fwd_idle_load got hit=%b stall=%b data=%h exp 0/0/0", bus.Fwd_Hit, bus.Ld_Stall, bus.Fwd_Data); else pass_cnt++;
    wait_empty("fwd");
  endtask

  task automatic test_partial_stall();
    hold_load(32'h0000_1000, 2'b00);
    push(32'h0000_0030, 32'hAAAA_5555, 2'b00, 1'b1);
    push(32'h0000_0031, 32'h0000_0077, 2'b10, 1'b1);
    hold_load(32'h0000_0030, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      total_cnt++; if (bus.Ld_Stall !== 1'b1 || bus.Fwd_Hit !== 1'b0 || bus.Mem_Write !== 1'b1)
        $display("FAIL partial_stall_c%0d got stall=%b hit=%b wr=%b exp 1/0/1", i, bus.Ld_Stall, bus.Fwd_Hit, bus.Mem_Write); else pass_cnt++;
      tick();
    end
    @(negedge Clk);
    total_cnt++; if (bus.Ld_Stall !== 1'b0 || bus.Fwd_Hit !== 1'b0 || bus.Empty !== 1'b1)
      $display("FAIL partial_release got stall=%b hit=%b empty=%b exp 0/0/1", bus.Ld_Stall, bus.Fwd_Hit, bus.Empty); else pass_cnt++;
    tick();
    bus.Ld_Valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d0;
    hold_load(32'h0000_1000, 2'b00);
    for (int i = 0; i < 3; i++) push(32'h400 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'b00, 1'b1);
    bus.Ld_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.St_Valid   = 1'b1;
      bus.St_Address = 32'h500 + 32'(4 * i);
      bus.St_Data    = 32'hD000_0000 + 32'(i);
      bus.St_Control = (i == 2) ? 2'b11 : 2'b00;
      exp_q.push_back({bus.St_Address, bus.St_Data, bus.St_Control});
      @(negedge Clk);
      total_cnt++; if (bus.St_Ready !== 1'b1 || bus.Mem_Write !== 1'b1 || bus.Empty !== 1'b0)
        $display("FAIL b2b_cycle%0d got rdy=%b wr=%b empty=%b exp 1/1/0", i, bus.St_Ready, bus.Mem_Write, bus.Empty); else pass_cnt++;
      tick();
    end
    bus.St_Valid = 1'b0;
    hold_load(32'h0000_1000, 2'b00);
    #1;
    total_cnt++; if (bus.St_Ready !== 1'b1) $display("FAIL b2b_count3_ready got %b exp 1", bus.St_Ready); else pass_cnt++;
    push(32'h600, 32'hEEEE_0001, 2'b10, 1'b1);
    total_cnt++; if (bus.St_Ready !== 1'b0) $display("FAIL b2b_count4_full got %b exp 0", bus.St_Ready); else pass_cnt++;
    bus.Ld_Valid = 1'b0;
    d0 = drained;
    wait_empty("b2b");
    total_cnt++; if (drained - d0 != 4) $display("FAIL b2b_drain_count got %0d exp 4", drained - d0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    hold_load(32'h0000_1000, 2'b00);
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(4 * i), 32'hF000_0000 + 32'(i), 2'b00, 1'b1);
    exp_q.delete();
    Rst = 1'b1;
    bus.Ld_Valid = 1'b0;
    @(negedge Clk);
    total_cnt++; if (bus.Mem_Write !== 1'b0) $display("FAIL rst_mid_write_in_reset got %b exp 0", bus.Mem_Write); else pass_cnt++;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      total_cnt++; if (bus.Mem_Write !== 1'b0 || bus.Empty !== 1'b1)
        $display("FAIL rst_mid_after%0d got wr=%b empty=%b exp 0/1", i, bus.Mem_Write, bus.Empty); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    Rst            = 1'b1;
    bus.St_Valid   = 1'b0;
    bus.St_Address = '0;
    bus.St_Data    = '0;
    bus.St_Control = '0;
    bus.Ld_Valid   = 1'b0;
    bus.Ld_Address = '0;
    bus.Ld_Control = '0;
    test_reset();
    test_drain_one();
    test_full();
    test_forward();
    test_partial_stall();
    test_back_to_back();
    test_reset_mid();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL leftover_expected got %0d exp 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry FIFO write buffer between the MEM stage and the data memory. Stores from the pipeline are queued and drained into the memory's write port one per cycle whenever no load owns the port. Loads are checked against pending stores, which keeps them coherent: a word-matching `sw` is forwarded with lb/lh/lw alignment, and a partial store to the same word stalls the load until it has drained.

## Interface
Parameters:
- `DEPTH`, 4: entry count (power of two, ≥2).

Ports:
- `Clk` in 1: clock; all state updates on posedge.
- `Rst` in 1: synchronous, active-high reset.
- `St_Valid` in 1: store request this cycle.
- `St_Address` in 32: store byte address.
- `St_Data` in 32: store data; byte/half in low bits.
- `St_Control` in 2: 00 sw, 10 sb, 11 sh (01 treated as sw).
- `St_Ready` out 1: buffer not full.
- `Ld_Valid` in 1: load request this cycle.
- `Ld_Address` in 32: load byte address.
- `Ld_Control` in 2: 00 lw, 10 lb, 11 lh.
- `Ld_Stall` out 1: load must hold; pipeline freezes.
- `Fwd_Hit` out 1: `Fwd_Data` replaces the memory read data.
- `Fwd_Data` out 32: aligned, sign-extended forwarded load value.
- `Mem_Write` out 1: write strobe to data memory.
- `Mem_Address` out 32: head entry address.
- `Mem_Write_Data` out 32: head entry data.
- `Mem_Store_Control` out 2: head entry control.
- `Empty` out 1: no pending stores.

## Operation
- Entry fields: valid, address[31:0], data[31:0], control[1:0]. Circular storage with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- **Push:** on posedge, when `St_Valid && St_Ready`, write the entry at tail and advance tail.
  - `St_Valid` while full is a protocol error: the store is dropped and state is unchanged.
- **Drain:** `Mem_Write = !Empty && (!Ld_Valid || Ld_Stall)`.
  - `Mem_*` is driven combinationally from the head entry.
  - On a posedge with `Mem_Write=1`, pop the head.
  - Address, data and control pass through unmodified; the memory performs byte placement.
- **Push and pop in the same cycle:** both take effect; count is unchanged.
- **Match rule:** an entry matches the load when valid and `entry.address[15:2] == Ld_Address[15:2]`. Only the youngest matching entry is considered.
- **Youngest match is sw:** `Fwd_Hit=1`, `Ld_Stall=0`. `Fwd_Data` uses memory-identical extraction:
  - lw: the whole word.
  - lb: byte selected by `Ld_Address[1:0]` (11→[7:0], 10→[15:8], 01→[23:16], 00→[31:24]), sign-extended.
  - lh: half selected by `Ld_Address[1:0]` (01→[15:0], 00→[31:16]), sign-extended.
  - lh with `Ld_Address[1:0]` of 10 or 11: `Fwd_Data` = 0.
- **Youngest match is sb/sh:** `Ld_Stall=1`, `Fwd_Hit=0`. Draining continues until no match remains.
- **No match:** `Ld_Stall=0`, `Fwd_Hit=0`; the load reads memory normally.
- `Fwd_Hit`, `Ld_Stall` and `Fwd_Data` are 0 whenever `Ld_Valid=0`.
- **St_Valid and Ld_Valid together:** the load is evaluated against the pre-push contents; the push still occurs.

## Timing
- Reset values:
  - count 0, head/tail 0, all valid bits 0.
  - `Empty=1`, `St_Ready=1`, `Mem_Write=0`.
  - `Mem_Address`, `Mem_Write_Data`, `Mem_Store_Control`, `Fwd_Data` = 0.
  - `Fwd_Hit=0`, `Ld_Stall=0`.
- Reset mid-operation discards all pending stores; no write is issued in the reset cycle.
- Push latency: a store accepted at edge N is visible at the head (and eligible to drain) from cycle N+1. There is no same-cycle bypass to memory.
- Drain: one entry per cycle; the memory commits on the same posedge the head pops.
- `St_Ready`, `Empty`, `Ld_Stall`, `Fwd_Hit` and `Fwd_Data` are combinational from registered state and the current-cycle load inputs.
- `St_Ready` depends on count only and does not anticipate a same-cycle pop.
- A stalled load re-evaluates every cycle. The stall drops in the cycle after the last matching entry pops.
- Pointers wrap modulo DEPTH.

## Configuration
- `STORE_FWD_EN`
  - **Defined:** forwarding as described above.
  - **Undefined:** `Fwd_Hit` and `Fwd_Data` are tied 0, and any matching entry (sw included) asserts `Ld_Stall` until drained.

## Test plan
- **Reset, then drain one store:** reset, push sw 0x0000_0010 / 0xDEAD_BEEF with no loads.
  - Cycle after push: `Mem_Write=1`, `Mem_Address=0x10`.
  - Next cycle: `Empty=1`.
- **Full:** push 4 stores while a load is held with no match.
  - `St_Ready=0`.
  - A 5th push is dropped.
  - Releasing the load drains all 4 in FIFO order over 4 consecutive cycles.
- **Forward:** buffer holds sw 0x20 / 0x80FF_1234; load 0x23 lb.
  - `Fwd_Hit=1`, `Fwd_Data=0x0000_0034`.
  - lh at 0x20 gives `0xFFFF_80FF`.
  - With `STORE_FWD_EN` undefined: `Ld_Stall=1` instead.
- **Partial stall:** buffer holds sw 0x30, then sb 0x31; load 0x30 lw.
  - `Ld_Stall=1` while either entry remains.
  - Drains in 2 cycles, then `Ld_Stall=0`, `Fwd_Hit=0`.
- **Simultaneous push/pop at count 3:** count stays 3 and the pointers wrap correctly past entry 3.
- **Reset mid-drain:** 3 pending stores, assert `Rst` for 1 cycle.
  - No `Mem_Write` during or after reset.
  - `Empty=1`.
